intersection_controller: RTL and testbench

INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

---
 rtl/intersection_controller_pkg.sv | 45 ++++
 rtl/intersection_controller_phase_timer.sv | 41 ++++
 rtl/intersection_controller.sv | 142 ++++++++++++++
 tb/tb_intersection_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/intersection_controller_pkg.sv
// Shared definitions for the intersection controller: lamp encodings,
// phase codes, tick-counter width and a phase-to-lamp decode helper.
package intersection_controller_pkg;

    localparam int TICK_W = 8;

    // Lamp vectors are indexed [0:2] so the literal reads R,G,Y left to right.
    typedef logic [0:2] lamp_t;

    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_GREEN  = 3'b010;
    localparam lamp_t LAMP_YELLOW = 3'b001;

    typedef enum logic [2:0] {
        PH_MAIN_GREEN  = 3'd0,
        PH_MAIN_YELLOW = 3'd1,
        PH_ALL_RED_1   = 3'd2,
        PH_SIDE_GREEN  = 3'd3,
        PH_SIDE_YELLOW = 3'd4,
        PH_ALL_RED_2   = 3'd5,
        PH_WALK        = 3'd6
    } phase_e;

    typedef struct packed {
        lamp_t main_lamp;
        lamp_t side_lamp;
    } lamps_t;

    // Any phase without a vehicle green/yellow (all-red, walk, illegal codes)
    // shows red on both roads, which keeps the conflict-free property by construction.
    function automatic lamps_t lamps_for(phase_e ph);
        lamps_t l;
        l.main_lamp = LAMP_RED;
        l.side_lamp = LAMP_RED;
        case (ph)
            PH_MAIN_GREEN:  l.main_lamp = LAMP_GREEN;
            PH_MAIN_YELLOW: l.main_lamp = LAMP_YELLOW;
            PH_SIDE_GREEN:  l.side_lamp = LAMP_GREEN;
            PH_SIDE_YELLOW: l.side_lamp = LAMP_YELLOW;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// phase_timer: loadable saturating down-counter that times each phase.
// Loading wins over counting; the count rests at zero until the next load.
module phase_timer
    import intersection_controller_pkg::*;
#(
    parameter logic [TICK_W-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [TICK_W-1:0] load_val,
    output logic              zero
);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;

    // Next count: reload on phase entry, otherwise count down and stop at zero.
    always_comb begin
        // NOTE: default assigned first so no path through the block infers a latch.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignment for all clocked state.
        if (!reset_n) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// intersection_controller: main/side road traffic light sequencer with an
// optional pedestrian walk phase, enabled by defining INTERSECTION_PED_WALK_EN.
// Without that macro ped_req is ignored, walk is tied low and WALK is unreachable.
module intersection_controller
    import intersection_controller_pkg::*;
#(
    parameter int MAIN_MIN_TICKS   = 8,
    parameter int SIDE_GREEN_TICKS = 6,
    parameter int YELLOW_TICKS     = 3,
    parameter int ALL_RED_TICKS    = 2,
    parameter int WALK_TICKS       = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [0:2] main_light,
    output logic [0:2] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    phase_e            phase_q;
    phase_e            phase_d;
    lamp_t             main_light_q;
    lamp_t             side_light_q;
    lamps_t            lamps_d;
    logic              side_pend_q;
    logic              side_pend_d;
    logic              ped_pend;
    logic              timer_load;
    logic [TICK_W-1:0] timer_load_val;
    logic              timer_zero;

    // Timer load value for a phase: ticks-1, so the phase lasts exactly `ticks` cycles.
    function automatic logic [TICK_W-1:0] ticks_minus1(phase_e ph);
        case (ph)
            PH_MAIN_GREEN:  return TICK_W'(MAIN_MIN_TICKS - 1);
            PH_MAIN_YELLOW,
            PH_SIDE_YELLOW: return TICK_W'(YELLOW_TICKS - 1);
            PH_SIDE_GREEN:  return TICK_W'(SIDE_GREEN_TICKS - 1);
            PH_WALK:        return TICK_W'(WALK_TICKS - 1);
            default:        return TICK_W'(ALL_RED_TICKS - 1);
        endcase
    endfunction

    // Next phase from the current phase, timer expiry and pending requests.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_MAIN_GREEN:  if (timer_zero && (side_pend_q || ped_pend)) phase_d = PH_MAIN_YELLOW;
            PH_MAIN_YELLOW: if (timer_zero) phase_d = PH_ALL_RED_1;
`ifdef INTERSECTION_PED_WALK_EN
            PH_ALL_RED_1:   if (timer_zero) phase_d = side_pend_q ? PH_SIDE_GREEN : PH_WALK;
`else
            PH_ALL_RED_1:   if (timer_zero) phase_d = PH_SIDE_GREEN;
`endif
            PH_SIDE_GREEN:  if (timer_zero) phase_d = PH_SIDE_YELLOW;
            PH_SIDE_YELLOW: if (timer_zero) phase_d = PH_ALL_RED_2;
            PH_ALL_RED_2:   if (timer_zero) phase_d = ped_pend ? PH_WALK : PH_MAIN_GREEN;
`ifdef INTERSECTION_PED_WALK_EN
            PH_WALK:        if (timer_zero) phase_d = PH_MAIN_GREEN;
`endif
            // Illegal codes (and WALK when the feature is absent) recover via all-red.
            default:        phase_d = PH_ALL_RED_2;
        endcase
    end

    // Timer reloads whenever the phase changes; lamps decode from the next phase
    // so the registered lamps switch on the same edge as the phase.
    always_comb begin
        timer_load     = (phase_d != phase_q);
        timer_load_val = ticks_minus1(phase_d);
        lamps_d        = lamps_for(phase_d);
        // A request in the entry cycle is absorbed by the phase that serves it.
        side_pend_d    = (side_pend_q | side_req) &
                         ~(timer_load && (phase_d == PH_SIDE_GREEN));
    end

    phase_timer #(
        .RESET_VAL (TICK_W'(ALL_RED_TICKS - 1))
    ) u_phase_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    // Phase, side request latch and registered lamp outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= PH_ALL_RED_2;
            side_pend_q  <= 1'b0;
            main_light_q <= LAMP_RED;
            side_light_q <= LAMP_RED;
        end else begin
            phase_q      <= phase_d;
            side_pend_q  <= side_pend_d;
            main_light_q <= lamps_d.main_lamp;
            side_light_q <= lamps_d.side_lamp;
        end
    end

`ifdef INTERSECTION_PED_WALK_EN
    logic ped_pend_q;
    logic ped_pend_d;
    logic walk_q;
    logic walk_d;

    // Pedestrian latch and walk lamp, following the same rules as the side latch.
    always_comb begin
        ped_pend_d = (ped_pend_q | ped_req) & ~(timer_load && (phase_d == PH_WALK));
        walk_d     = (phase_d == PH_WALK);
    end

    // Pedestrian state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
        end
    end

    assign ped_pend = ped_pend_q;
    assign walk     = walk_q;
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_pend       = 1'b0;
    assign walk           = 1'b0;
`endif

    assign main_light = main_light_q;
    assign side_light = side_light_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller (default parameters).
// Reference model tracks phase name, elapsed cycles and request latches
// against a duration table; builds with or without INTERSECTION_PED_WALK_EN.
module tb_intersection_controller;

    localparam int P_MG  = 0;
    localparam int P_MY  = 1;
    localparam int P_AR1 = 2;
    localparam int P_SG  = 3;
    localparam int P_SY  = 4;
    localparam int P_AR2 = 5;
    localparam int P_WK  = 6;

    localparam logic [0:2] RED = 3'b100;
    localparam logic [0:2] GRN = 3'b010;
    localparam logic [0:2] YEL = 3'b001;

`ifdef INTERSECTION_PED_WALK_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       side_req;
    logic       ped_req;
    logic [0:2] main_light;
    logic [0:2] side_light;
    logic       walk;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_bad = 0;

    int m_phase;
    int m_elapsed;
    bit m_side;
    bit m_ped;

    always #5 clock = ~clock;

    intersection_controller dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    function automatic int dur(int p);
        case (p)
            P_MG:       return 8;
            P_MY, P_SY: return 3;
            P_SG:       return 6;
            P_WK:       return 5;
            default:    return 2;
        endcase
    endfunction

    function automatic logic [0:2] exp_main(int p);
        if (p == P_MG) return GRN;
        if (p == P_MY) return YEL;
        return RED;
    endfunction

    function automatic logic [0:2] exp_side(int p);
        if (p == P_SG) return GRN;
        if (p == P_SY) return YEL;
        return RED;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_AR2;
        m_elapsed = 1;
        m_side    = 1'b0;
        m_ped     = 1'b0;
    endtask

    // One clock of the traffic rules, using the inputs present at the edge.
    task automatic model_step();
        bit last;
        int nxt;
        last = (m_elapsed >= dur(m_phase));
        nxt  = m_phase;
        case (m_phase)
            P_MG:  if (last && (m_side || m_ped)) nxt = P_MY;
            P_MY:  if (last) nxt = P_AR1;
            P_AR1: if (last) nxt = (m_side || !PED_EN) ? P_SG : P_WK;
            P_SG:  if (last) nxt = P_SY;
            P_SY:  if (last) nxt = P_AR2;
            P_AR2: if (last) nxt = m_ped ? P_WK : P_MG;
            P_WK:  if (last) nxt = P_MG;
            default: nxt = P_AR2;
        endcase
        m_side    = (m_side || side_req) && !(nxt == P_SG && m_phase != P_SG);
        m_ped     = PED_EN && (m_ped || ped_req) && !(nxt == P_WK && m_phase != P_WK);
        m_elapsed = (nxt != m_phase) ? 1 : m_elapsed + 1;
        m_phase   = nxt;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_phase"}, 32'(phase), 32'(m_phase));
        check({tag, "_main"},  32'(main_light), 32'(exp_main(m_phase)));
        check({tag, "_side"},  32'(side_light), 32'(exp_side(m_phase)));
        check({tag, "_walk"},  32'(walk), 32'(m_phase == P_WK));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_phase", 32'(phase), 32'(P_AR2));
        check("rst_main",  32'(main_light), 32'(RED));
        check("rst_side",  32'(side_light), 32'(RED));
        check("rst_walk",  32'(walk), 32'(0));
        model_reset();
        reset_n = 1'b1;
    endtask

    // Conflict-free lamps on every cycle outside reset.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            n_cmp++;
            assert (!(main_light !== RED && side_light !== RED) &&
                    (walk !== 1'b1 || (main_light === RED && side_light === RED))) else begin
                n_bad++;
                $error("FAIL lamp_safety: main=%b side=%b walk=%b, expected no conflict",
                       main_light, side_light, walk);
            end
        end
    end

    initial begin
        side_req = 1'b0;
        ped_req  = 1'b0;
        @(negedge clock);
        do_reset();

        // Idle: all-red clearance then main green held.
        repeat (50) tick("idle");

        // Single side pulse in the second main-green cycle.
        do_reset();
        repeat (3) tick("pulse_pre");
        side_req = 1'b1;
        tick("pulse");
        side_req = 1'b0;
        repeat (30) tick("side_seq");

        // Pedestrian only.
        ped_req = 1'b1;
        tick("ped_pulse");
        ped_req = 1'b0;
        repeat (40) tick("ped_seq");

        // Side and pedestrian held together, then released.
        side_req = 1'b1;
        ped_req  = 1'b1;
        repeat (40) tick("both_held");
        side_req = 1'b0;
        ped_req  = 1'b0;
        repeat (30) tick("both_rel");

        // Asynchronous reset in the middle of side green.
        side_req = 1'b1;
        for (int i = 0; i < 40 && m_phase != P_SG; i++) tick("to_sg");
        side_req = 1'b0;
        tick("in_sg");
        check("reach_side_green", 32'(phase), 32'(P_SG));
        #2 reset_n = 1'b0;
        #1;
        check("async_phase", 32'(phase), 32'(P_AR2));
        check("async_main",  32'(main_light), 32'(RED));
        check("async_side",  32'(side_light), 32'(RED));
        check("async_walk",  32'(walk), 32'(0));
        repeat (2) @(negedge clock);
        model_reset();
        reset_n = 1'b1;
        repeat (20) tick("post_rst");

        // Pedestrian button held down.
        ped_req = 1'b1;
        repeat (40) tick("ped_held");
        ped_req = 1'b0;
        repeat (30) tick("ped_rel");

        // Random request traffic.
        repeat (800) begin
            side_req = ($urandom_range(0, 15) == 0);
            ped_req  = ($urandom_range(0, 19) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
